// File: rtl/dual_fetch_queue.sv
// dual_fetch_queue: PC generator plus circular instruction queue for a
// 2-way superscalar front end. Each cycle a pc/pc4 instruction pair is
// fetched and enqueued as a pair. Decode pops 0..2 entries from the head.
// A branch redirect flushes the queue and reloads the PC.
module dual_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_en,
  input  logic [63:0]      branch_pc,
  output logic [63:0]      pc,
  output logic [63:0]      pc4,
  input  logic [31:0]      instr1,
  input  logic [31:0]      instr2,
  input  logic [1:0]       deq_cnt,
  output logic             out_valid0,
  output logic [31:0]      out_instr0,
  output logic [63:0]      out_pc0,
  output logic             out_valid1,
  output logic [31:0]      out_instr1,
  output logic [63:0]      out_pc1,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);

  // Queue storage; contents are don't-care after reset or flush.
  logic [31:0] ent_instr_q [DEPTH];
  logic [63:0] ent_pc_q    [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      pc4_q, pc4_d;

  logic [1:0]       deq_req_s;
  logic [CNT_W-1:0] deq_eff_s;
  logic [CNT_W:0]   free_s;
  logic             enq_s;
  logic [PTR_W-1:0] head_p1_s;
  logic [PTR_W-1:0] tail_p1_s;
  logic             valid0_s;
  logic             valid1_s;

  // Dequeue clamping and the paired-enqueue decision.
  always_comb begin
    deq_req_s = 2'd0;
    deq_eff_s = '0;
    free_s    = '0;
    enq_s     = 1'b0;
    if (deq_cnt == 2'd3) begin
      deq_req_s = 2'd2;
    end else begin
      deq_req_s = deq_cnt;
    end
    if (CNT_W'(deq_req_s) > count_q) begin
      deq_eff_s = count_q;
    end else begin
      deq_eff_s = CNT_W'(deq_req_s);
    end
    free_s = DEPTH_W - {1'b0, count_q} + {1'b0, deq_eff_s};
    if (!branch_en && (free_s >= (CNT_W+1)'(2))) begin
      enq_s = 1'b1;
    end else begin
      enq_s = 1'b0;
    end
  end

  // Next-state for pointers, occupancy and fetch PC; redirect flushes.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (branch_en) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = branch_pc & ~64'd3;
      pc4_d   = (branch_pc & ~64'd3) + 64'd4;
    end else begin
      head_d = head_q + PTR_W'(deq_eff_s);
      if (enq_s) begin
        tail_d  = tail_q + PTR_W'(2);
        count_d = count_q - deq_eff_s + CNT_W'(2);
        pc_d    = pc_q + 64'd8;
        pc4_d   = pc4_q + 64'd8;
      end else begin
        count_d = count_q - deq_eff_s;
      end
    end
  end

  // Control registers with synchronous reset; reset beats redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= 64'd0;
      pc4_q   <= 64'd4;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign tail_p1_s = tail_q + PTR_W'(1);
  assign head_p1_s = head_q + PTR_W'(1);

  // Pair write into storage; DEPTH is even so tail and tail+1 never collide.
  always_ff @(posedge clk) begin
    if (!rst && enq_s) begin
      ent_instr_q[tail_q]    <= instr1;
      ent_pc_q[tail_q]       <= pc_q;
      ent_instr_q[tail_p1_s] <= instr2;
      ent_pc_q[tail_p1_s]    <= pc4_q;
    end
  end

  assign valid0_s = (count_q != '0);
  assign valid1_s = (count_q >= CNT_W'(2));

  // Head and head+1 read ports, zeroed when the slot is not occupied.
  always_comb begin
    out_instr0 = 32'd0;
    out_pc0    = 64'd0;
    out_instr1 = 32'd0;
    out_pc1    = 64'd0;
    if (valid0_s) begin
      out_instr0 = ent_instr_q[head_q];
      out_pc0    = ent_pc_q[head_q];
    end else begin
      out_instr0 = 32'd0;
      out_pc0    = 64'd0;
    end
    if (valid1_s) begin
      out_instr1 = ent_instr_q[head_p1_s];
      out_pc1    = ent_pc_q[head_p1_s];
    end else begin
      out_instr1 = 32'd0;
      out_pc1    = 64'd0;
    end
  end

  assign out_valid0 = valid0_s;
  assign out_valid1 = valid1_s;
  assign count      = count_q;
  assign pc         = pc_q;
  assign pc4        = pc4_q;

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Self-checking bench for dual_fetch_queue: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_dual_fetch_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             branch_en;
  logic [63:0]      branch_pc;
  logic [63:0]      pc;
  logic [63:0]      pc4;
  logic [31:0]      instr1;
  logic [31:0]      instr2;
  logic [1:0]       deq_cnt;
  logic             out_valid0;
  logic [31:0]      out_instr0;
  logic [63:0]      out_pc0;
  logic             out_valid1;
  logic [31:0]      out_instr1;
  logic [63:0]      out_pc1;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  dual_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .branch_en(branch_en), .branch_pc(branch_pc),
    .pc(pc), .pc4(pc4), .instr1(instr1), .instr2(instr2), .deq_cnt(deq_cnt),
    .out_valid0(out_valid0), .out_instr0(out_instr0), .out_pc0(out_pc0),
    .out_valid1(out_valid1), .out_instr1(out_instr1), .out_pc1(out_pc1),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a few fixed words, a hash everywhere else.
  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'h0:    imem = 32'h015A04B3;
      64'h4:    imem = 32'h00148493;
      64'h8:    imem = 32'hF0953823;
      64'h54:   imem = 32'h014AEA13;
      64'h58:   imem = 32'h7FFAF993;
      default:  imem = (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5BD1E995;
    endcase
  endfunction

  assign instr1 = imem(pc);
  assign instr2 = imem(pc4);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {instr, pc} entries and a fetch PC.
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc;
  bit          m_ready = 1'b0;

  always @(posedge clk) begin
    int d;
    if (rst) begin
      mq.delete();
      m_pc = 64'd0;
      m_ready = 1'b1;
    end else if (branch_en) begin
      mq.delete();
      m_pc = {branch_pc[63:2], 2'b00};
    end else begin
      d = (deq_cnt == 2'd3) ? 2 : int'(deq_cnt);
      if (d > mq.size()) d = mq.size();
      repeat (d) void'(mq.pop_front());
      if (DEPTH - mq.size() >= 2) begin
        mq.push_back({imem(m_pc), m_pc});
        mq.push_back({imem(m_pc + 64'd4), m_pc + 64'd4});
        m_pc = m_pc + 64'd8;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc4", pc4, m_pc + 64'd4);
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_valid0", 64'(out_valid0), 64'(mq.size() >= 1));
      chk("m_valid1", 64'(out_valid1), 64'(mq.size() >= 2));
      chk("m_instr0", 64'(out_instr0), (mq.size() >= 1) ? 64'(mq[0].instr) : 64'd0);
      chk("m_pc0", out_pc0, (mq.size() >= 1) ? mq[0].pc : 64'd0);
      chk("m_instr1", 64'(out_instr1), (mq.size() >= 2) ? 64'(mq[1].instr) : 64'd0);
      chk("m_pc1", out_pc1, (mq.size() >= 2) ? mq[1].pc : 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; branch_en = 1'b0; branch_pc = 64'd0; deq_cnt = 2'd0;

    // Reset held two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_pc", pc, 64'd0);
      chk("rst_pc4", pc4, 64'd4);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_v0", 64'(out_valid0), 64'd0);
      chk("rst_v1", 64'(out_valid1), 64'd0);
    end

    // First pair after release
    rst = 1'b0;
    tick();
    chk("first_count", 64'(count), 64'd2);
    chk("first_instr0", 64'(out_instr0), 64'h015A04B3);
    chk("first_pc0", out_pc0, 64'd0);
    chk("first_instr1", 64'(out_instr1), 64'h00148493);
    chk("first_pc1", out_pc1, 64'd4);
    chk("first_pc", pc, 64'd8);

    // Fill to full, then hold
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_count", 64'(count), (i < 3) ? 64'(4 + 2*i) : 64'd8);
      chk("fill_pc", pc, (i < 3) ? 64'(16 + 8*i) : 64'd32);
    end

    // Full with sustained pair dequeue across the pointer wrap
    deq_cnt = 2'd2;
    for (int i = 0; i < 4; i++) begin
      chk("full_pc0", out_pc0, 64'(8*i));
      tick();
      chk("full_count", 64'(count), 64'd8);
      chk("full_pc", pc, 64'(40 + 8*i));
      if (i == 0) chk("entry2_instr", 64'(out_instr0), 64'hF0953823);
    end
    chk("full_pc0_end", out_pc0, 64'd32);

    // Near-full stall boundaries
    deq_cnt = 2'd1;
    tick();
    chk("stall7_count", 64'(count), 64'd7);
    chk("stall7_pc", pc, 64'd64);
    deq_cnt = 2'd0;
    tick();
    chk("stall7b_count", 64'(count), 64'd7);
    chk("stall7b_pc", pc, 64'd64);
    deq_cnt = 2'd2;
    tick();
    chk("unstall_count", 64'(count), 64'd7);
    chk("unstall_pc", pc, 64'd72);

    // Flush, then odd dequeue and deq_cnt=3
    branch_en = 1'b1; branch_pc = 64'd0;
    tick();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_v0", 64'(out_valid0), 64'd0);
    branch_en = 1'b0; deq_cnt = 2'd2;
    tick();
    chk("empty_deq_count", 64'(count), 64'd2);
    deq_cnt = 2'd1;
    tick();
    chk("odd_count", 64'(count), 64'd3);
    chk("odd_pc0", out_pc0, 64'd4);
    deq_cnt = 2'd3;
    tick();
    chk("deq3_count", 64'(count), 64'd3);
    chk("deq3_pc0", out_pc0, 64'd12);

    // Redirect with count=6
    deq_cnt = 2'd1;
    tick();
    deq_cnt = 2'd0;
    tick();
    chk("pre_br_count", 64'(count), 64'd6);
    deq_cnt = 2'd2; branch_en = 1'b1; branch_pc = 64'h56;
    tick();
    chk("br_count", 64'(count), 64'd0);
    chk("br_v0", 64'(out_valid0), 64'd0);
    chk("br_v1", 64'(out_valid1), 64'd0);
    chk("br_pc", pc, 64'h54);
    chk("br_pc4", pc4, 64'h58);
    deq_cnt = 2'd0; branch_en = 1'b0;
    tick();
    chk("br_instr0", 64'(out_instr0), 64'h014AEA13);
    chk("br_pc0", out_pc0, 64'h54);
    chk("br_instr1", 64'(out_instr1), 64'h7FFAF993);
    chk("br_pc1", out_pc1, 64'h58);

    // Reset beats redirect
    tick();
    tick();
    chk("pre_rst_count", 64'(count), 64'd6);
    rst = 1'b1; branch_en = 1'b1; branch_pc = 64'h100;
    tick();
    chk("rst_win_pc", pc, 64'd0);
    chk("rst_win_count", 64'(count), 64'd0);
    rst = 1'b0; branch_en = 1'b0;

    // Randomized traffic, including redirects near the top of the address space
    for (int i = 0; i < 3000; i++) begin
      deq_cnt   = 2'($urandom_range(0, 3));
      branch_en = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        branch_pc = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31));
      else
        branch_pc = {32'($urandom), 32'($urandom)};
      rst = ($urandom_range(0, 199) == 0);
      if (i % 97 < 10) deq_cnt = 2'd0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_fetch_queue.md
Name: dual_fetch_queue

Overview:
PC generator and instruction queue for the 2-way superscalar front end. It drives pc/pc4 to the instruction memory and captures the returned instr1/instr2 pair each cycle. The pair is tagged with its PCs and buffered in a circular queue. Dual decode pops 0, 1 or 2 instructions per cycle from the head, and a branch redirect flushes the queue and reloads the PC.

Parameters:
DEPTH, 8, queue entries; power of two, minimum 4.
CNT_W, 4, width of count output; must be at least log2(DEPTH)+1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
branch_en  input  1  redirect request from execute.
branch_pc  input  64  redirect target; bits [1:0] ignored, treated as 0.
pc  output  64  fetch address 1 to the instruction memory (registered).
pc4  output  64  fetch address 2; always equals pc+4 modulo 2^64.
instr1  input  32  memory word at pc; combinational function of pc.
instr2  input  32  memory word at pc4.
deq_cnt  input  2  entries decode consumes this cycle.
out_valid0  output  1  head entry valid.
out_instr0  output  32  head instruction.
out_pc0  output  64  head PC.
out_valid1  output  1  head+1 entry valid.
out_instr1  output  32  head+1 instruction.
out_pc1  output  64  head+1 PC.
count  output  CNT_W  occupied entries, 0..DEPTH.

Behaviour:
- Reset (rst=1 at the edge): pc=0, pc4=4, head=tail=0, count=0.
  - Reset has priority over branch_en, deq_cnt and enqueue.
  - Storage contents are don't-care.
- Output ports:
  - out_valid0 = (count>=1); out_valid1 = (count>=2). Both are combinational from registers.
  - out_instr*/out_pc* read the queue at head / head+1.
  - When the matching valid is 0, out_instr* and out_pc* are driven to 0.
- Effective dequeue:
  - deq_eff = min(deq_cnt, 2, count). deq_cnt=3 is treated as 2, and requests beyond count are clamped.
  - head advances by deq_eff, modulo DEPTH.
- Enqueue rule:
  - free = DEPTH - count + deq_eff.
  - If branch_en=0 and free>=2, write {instr1, pc} at tail and {instr2, pc4} at tail+1, then tail += 2 and pc/pc4 += 8.
  - Otherwise no write and pc/pc4 hold (fetch stall).
  - Enqueue is always a pair; a single-entry enqueue never happens.
- Count update: count_next = count - deq_eff + (enq ? 2 : 0).
- Branch redirect (branch_en=1, rst=0):
  - count=0 and head=tail=0 next cycle; the queue is flushed.
  - pc=branch_pc with bits [1:0]=0; pc4 = that value + 4.
  - deq_cnt and the current instr1/instr2 are ignored that cycle.
  - Redirect the cycle after redirect is legal; last one wins.
- Latency: the pair fetched at pc in cycle N is visible on out_* in cycle N+1 if the queue was empty. Redirect-to-first-valid is 2 edges.
- Wrap-around:
  - Queue pointers wrap modulo DEPTH.
  - pc wraps modulo 2^64 with no error.
  - Because DEPTH is even and enqueue is paired, tail+1 never straddles a wrap incorrectly with modulo indexing.
- Full/empty boundaries:
  - count=DEPTH with deq_eff=2: enqueue proceeds and count stays DEPTH.
  - count=DEPTH-1 with deq_eff=0: stall.
  - count=0: deq_cnt has no effect.
- Implementation is edge-triggered registers only; no latches and no combinational path from deq_cnt to pc.

Test Plan:
1. Reset: rst=1 for 2 cycles, then released with deq_cnt=0 -> pc=0, pc4=4, count=0, out_valid0/1=0 in the reset cycles.
   - Next cycle: count=2, out_instr0=0x015A04B3 (pc 0), out_instr1=0x00148493 (pc 4).
2. Fill to full, DEPTH=8, deq_cnt=0 -> pc sequence 0,8,16,24,32 then holds at 32; count 2,4,6,8,8.
   - Entry 2 = 0xF0953823 at pc 8, reached after deq_cnt=2 once.
3. Full with deq_cnt=2 sustained 4 cycles -> count stays 8, pc advances 8 per cycle.
   - out_pc0 steps 0,8,16,24; no lost or duplicated PCs across the pointer wrap.
4. Odd dequeue: count=2, deq_cnt=1 -> count=3, out_pc0=4.
   - Then deq_cnt=3 -> treated as 2, count=3.
   - Then count=1 with deq_cnt=2 -> clamps, count=2, no underflow.
5. Redirect: count=6, deq_cnt=2, branch_en=1, branch_pc=0x56 -> next edge count=0, valids 0, pc=0x54, pc4=0x58.
   - Following edge: out_instr0=0x014AEA13 (pc 0x54), out_instr1=0x7FFAF993 (pc 0x58).
6. Reset mid-operation: count=6, branch_en=1 and rst=1 in the same cycle -> pc=0, count=0; reset wins over redirect.
